// File: rtl/wb_target_arbiter.sv
// wb_target_arbiter: Wishbone cycle controller routing host cycles to regs/UART0/UART1 with default-value completion.
// Optional WAIT-state timeout is built when WB_ARB_TIMEOUT_EN is defined.
module wb_target_arbiter #(
   parameter int                   ADDRWIDTH      = 10,
   parameter int                   DATAWIDTH      = 32,
   parameter int                   SEL_LSB        = 8,
   parameter int                   TIMEOUT_CYCLES = 255,
   parameter logic [DATAWIDTH-1:0] DEF_REG_VALUE  = 32'hFABDEFAC
) (
   input  logic                   WBs_CLK_i,
   input  logic                   WBs_RST_i,
   input  logic [ADDRWIDTH-1:0]   WBs_ADR_i,
   input  logic                   WBs_CYC_i,
   input  logic                   WBs_STB_i,
   input  logic                   WBs_WE_i,
   output logic [DATAWIDTH-1:0]   WBs_DAT_o,
   output logic                   WBs_ACK_o,
   output logic [2:0]             Tgt_CYC_o,
   output logic                   Tgt_STB_o,
   input  logic [3*DATAWIDTH-1:0] Tgt_DAT_i,
   input  logic [2:0]             Tgt_ACK_i,
   output logic                   Timeout_Flag_o,
   input  logic                   Timeout_Clr_i
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t               r_state, w_state_nxt;
   logic [1:0]           r_sel, w_sel_nxt, w_sel;
   logic [2:0]           r_cyc, w_cyc_nxt;
   logic                 r_stb, w_stb_nxt, r_ack, w_ack_nxt, r_flag, w_flag_nxt;
   logic                 w_set, w_req, w_tgt_ack, w_timeout, w_unused;
   logic [DATAWIDTH-1:0] r_dat, w_dat_nxt, w_tgt_dat;

   assign w_sel     = WBs_ADR_i[SEL_LSB+1:SEL_LSB];
   assign w_req     = WBs_CYC_i & WBs_STB_i;
   assign w_tgt_ack = (r_sel == 2'd0) ? Tgt_ACK_i[0] : (r_sel == 2'd1) ? Tgt_ACK_i[1] : Tgt_ACK_i[2];
   assign w_tgt_dat = (r_sel == 2'd0) ? Tgt_DAT_i[DATAWIDTH-1:0] :
                      (r_sel == 2'd1) ? Tgt_DAT_i[2*DATAWIDTH-1:DATAWIDTH] :
                                        Tgt_DAT_i[3*DATAWIDTH-1:2*DATAWIDTH];

`ifdef WB_ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] r_cnt;
   assign w_timeout = (r_state == WAIT) && (r_cnt == TO_LAST);
   assign w_unused  = ^{WBs_WE_i, WBs_ADR_i};
   // Held at zero outside WAIT, so every WAIT entry starts counting from 0
   always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i)
      if (WBs_RST_i) r_cnt <= 8'd0;
      else           r_cnt <= (r_state == WAIT) ? r_cnt + 8'd1 : 8'd0;
`else
   assign w_timeout = 1'b0;
   assign w_unused  = ^{WBs_WE_i, WBs_ADR_i, 8'(TIMEOUT_CYCLES)};
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_cyc_nxt   = r_cyc;
      w_stb_nxt   = r_stb;
      w_dat_nxt   = r_dat;
      w_set       = 1'b0;
      case (r_state)
         IDLE: if (w_req) begin
            w_sel_nxt = w_sel;
            if (w_sel == 2'd3) begin
               w_dat_nxt   = DEF_REG_VALUE;
               w_set       = 1'b1;
               w_state_nxt = RESP;
            end else begin
               w_cyc_nxt   = 3'b001 << w_sel;
               w_stb_nxt   = 1'b1;
               w_state_nxt = WAIT;
            end
         end
         WAIT: if (w_tgt_ack) begin
            w_dat_nxt   = w_tgt_dat;
            w_cyc_nxt   = 3'b000;
            w_stb_nxt   = 1'b0;
            w_state_nxt = RESP;
         end else if (!WBs_CYC_i) begin
            w_cyc_nxt   = 3'b000;
            w_stb_nxt   = 1'b0;
            w_state_nxt = IDLE;
         end else if (w_timeout) begin
            w_dat_nxt   = DEF_REG_VALUE;
            w_cyc_nxt   = 3'b000;
            w_stb_nxt   = 1'b0;
            w_set       = 1'b1;
            w_state_nxt = RESP;
         end
         default: w_state_nxt = IDLE;
      endcase
      w_ack_nxt  = (w_state_nxt == RESP);
      w_flag_nxt = w_set | (r_flag & ~Timeout_Clr_i);
   end

   always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i)
      if (WBs_RST_i) begin
         r_state <= IDLE;
         r_sel   <= 2'd0;
         r_cyc   <= 3'b000;
         r_stb   <= 1'b0;
         r_ack   <= 1'b0;
         r_flag  <= 1'b0;
         r_dat   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_cyc   <= w_cyc_nxt;
         r_stb   <= w_stb_nxt;
         r_ack   <= w_ack_nxt;
         r_flag  <= w_flag_nxt;
         r_dat   <= w_dat_nxt;
      end

   assign WBs_DAT_o      = r_dat;
   assign WBs_ACK_o      = r_ack;
   assign Tgt_CYC_o      = r_cyc;
   assign Tgt_STB_o      = r_stb;
   assign Timeout_Flag_o = r_flag;
endmodule

// File: tb/tb_wb_target_arbiter.sv
// tb_wb_target_arbiter: directed self-checking bench for wb_target_arbiter.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_wb_target_arbiter;
   logic        clk = 1'b0, rst = 1'b1;
   logic [9:0]  adr = '0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, clr = 1'b0;
   logic [31:0] dat_o;
   logic        ack_o, stb_o, flag_o;
   logic [2:0]  cyc_o, tack = '0;
   logic [95:0] tdat = '0;
   int          vectors = 0, errors = 0;

   wb_target_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .WBs_CLK_i(clk), .WBs_RST_i(rst), .WBs_ADR_i(adr), .WBs_CYC_i(cyc), .WBs_STB_i(stb),
      .WBs_WE_i(we), .WBs_DAT_o(dat_o), .WBs_ACK_o(ack_o), .Tgt_CYC_o(cyc_o), .Tgt_STB_o(stb_o),
      .Tgt_DAT_i(tdat), .Tgt_ACK_i(tack), .Timeout_Flag_o(flag_o), .Timeout_Clr_i(clr));

   always #5 clk = ~clk;

   task automatic req(input logic [9:0] a, input logic w);
      adr = a; we = w; cyc = 1'b1; stb = 1'b1;
   endtask

   task automatic idle_host();
      cyc = 1'b0; stb = 1'b0; we = 1'b0; tack = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      vectors++;
      if ({dat_o, ack_o, cyc_o, stb_o, flag_o} !== 38'd0) begin
         errors++; $display("FAIL reset_outputs got=%h exp=0", {dat_o, ack_o, cyc_o, stb_o, flag_o});
      end
      rst = 1'b0;
   endtask

   task automatic test_regs_read();
      @(negedge clk); req(10'h000, 1'b0);
      @(negedge clk);
      vectors++;
      if (cyc_o !== 3'b001 || stb_o !== 1'b1 || ack_o !== 1'b0) begin
         errors++; $display("FAIL t1_strobe got cyc=%b stb=%b ack=%b exp cyc=001 stb=1 ack=0", cyc_o, stb_o, ack_o);
      end
      tack = 3'b001; tdat[31:0] = 32'h0ADC0001;
      @(negedge clk);
      vectors++;
      if (ack_o !== 1'b1 || dat_o !== 32'h0ADC0001 || cyc_o !== 3'b000) begin
         errors++; $display("FAIL t1_ack got ack=%b dat=%h cyc=%b exp ack=1 dat=0adc0001 cyc=000", ack_o, dat_o, cyc_o);
      end
      idle_host();
      @(negedge clk);
      vectors++;
      if (ack_o !== 1'b0 || dat_o !== 32'h0ADC0001) begin
         errors++; $display("FAIL t1_ack_width got ack=%b dat=%h exp ack=0 dat=0adc0001", ack_o, dat_o);
      end
   endtask

   task automatic test_uart0_write();
      int acks = 0;
      @(negedge clk); req(10'h104, 1'b1);
      tdat[63:32] = 32'h5A5A0002; tdat[95:64] = 32'hDEAD0003;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         vectors++;
         if (ack_o !== 1'b0 || cyc_o !== 3'b010) begin
            errors++; $display("FAIL t2_wait%0d got ack=%b cyc=%b exp ack=0 cyc=010", i, ack_o, cyc_o);
         end
         tack = (i == 5) ? 3'b010 : 3'b100;
      end
      @(negedge clk);
      vectors++;
      if (ack_o !== 1'b1 || dat_o !== 32'h5A5A0002) begin
         errors++; $display("FAIL t2_ack got ack=%b dat=%h exp ack=1 dat=5a5a0002", ack_o, dat_o);
      end
      idle_host();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         acks += int'(ack_o);
      end
      vectors++;
      if (acks != 0) begin
         errors++; $display("FAIL t2_single_ack got extra=%0d exp 0", acks);
      end
   endtask

   task automatic test_unmapped();
      @(negedge clk); req(10'h300, 1'b0);
      @(negedge clk);
      vectors++;
      if (ack_o !== 1'b1 || dat_o !== 32'hFABDEFAC || flag_o !== 1'b1 || cyc_o !== 3'b000) begin
         errors++; $display("FAIL t3_ack got ack=%b dat=%h flag=%b cyc=%b exp 1 fabdefac 1 000", ack_o, dat_o, flag_o, cyc_o);
      end
      idle_host();
      @(negedge clk);
      vectors++;
      if (ack_o !== 1'b0 || flag_o !== 1'b1) begin
         errors++; $display("FAIL t3_sticky got ack=%b flag=%b exp ack=0 flag=1", ack_o, flag_o);
      end
      clr = 1'b1;
      @(negedge clk);
      vectors++;
      if (flag_o !== 1'b0) begin
         errors++; $display("FAIL t3_clear got flag=%b exp 0", flag_o);
      end
      req(10'h3FC, 1'b0);
      @(negedge clk);
      vectors++;
      if (flag_o !== 1'b1 || ack_o !== 1'b1) begin
         errors++; $display("FAIL t3_set_over_clr got flag=%b ack=%b exp flag=1 ack=1", flag_o, ack_o);
      end
      idle_host();
      @(negedge clk);
      vectors++;
      if (flag_o !== 1'b0) begin
         errors++; $display("FAIL t3_clear2 got flag=%b exp 0", flag_o);
      end
      clr = 1'b0;
   endtask

   task automatic test_hung_target();
      @(negedge clk); req(10'h200, 1'b0);
`ifdef WB_ARB_TIMEOUT_EN
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         vectors++;
         if (cyc_o !== 3'b100 || ack_o !== 1'b0) begin
            errors++; $display("FAIL t4_wait%0d got cyc=%b ack=%b exp cyc=100 ack=0", i, cyc_o, ack_o);
         end
      end
      @(negedge clk);
      vectors++;
      if (cyc_o !== 3'b000 || ack_o !== 1'b1 || dat_o !== 32'hFABDEFAC || flag_o !== 1'b1) begin
         errors++; $display("FAIL t4_timeout got cyc=%b ack=%b dat=%h flag=%b exp 000 1 fabdefac 1", cyc_o, ack_o, dat_o, flag_o);
      end
      idle_host(); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
`else
      begin
         int bad = 0;
         for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ack_o !== 1'b0 || cyc_o !== 3'b100) bad++;
         end
         vectors++;
         if (bad != 0) begin
            errors++; $display("FAIL t4_hold got bad_cycles=%0d exp 0", bad);
         end
         vectors++;
         if (flag_o !== 1'b0) begin
            errors++; $display("FAIL t4_no_flag got flag=%b exp 0", flag_o);
         end
      end
      idle_host();
      @(negedge clk);
      vectors++;
      if (cyc_o !== 3'b000 || stb_o !== 1'b0 || ack_o !== 1'b0) begin
         errors++; $display("FAIL t4_abort got cyc=%b stb=%b ack=%b exp 000 0 0", cyc_o, stb_o, ack_o);
      end
`endif
   endtask

   task automatic test_abort();
      @(negedge clk); req(10'h0F0, 1'b0);
      @(negedge clk);
      @(negedge clk); idle_host();
      @(negedge clk);
      vectors++;
      if (cyc_o !== 3'b000 || stb_o !== 1'b0 || ack_o !== 1'b0) begin
         errors++; $display("FAIL t5_abort got cyc=%b stb=%b ack=%b exp 000 0 0", cyc_o, stb_o, ack_o);
      end
      @(negedge clk);
      vectors++;
      if (ack_o !== 1'b0) begin
         errors++; $display("FAIL t5_no_ack got ack=%b exp 0", ack_o);
      end
      req(10'h010, 1'b0); tdat[31:0] = 32'h0ADC0003;
      @(negedge clk); tack = 3'b001;
      @(negedge clk);
      vectors++;
      if (ack_o !== 1'b1 || dat_o !== 32'h0ADC0003) begin
         errors++; $display("FAIL t5_next got ack=%b dat=%h exp ack=1 dat=0adc0003", ack_o, dat_o);
      end
      idle_host();
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      @(negedge clk); req(10'h300, 1'b0);
      @(negedge clk); req(10'h104, 1'b0);
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (cyc_o !== 3'b010 || flag_o !== 1'b1) begin
         errors++; $display("FAIL t6_pre got cyc=%b flag=%b exp 010 1", cyc_o, flag_o);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({dat_o, ack_o, cyc_o, stb_o, flag_o} !== 38'd0) begin
         errors++; $display("FAIL t6_async got %h exp 0", {dat_o, ack_o, cyc_o, stb_o, flag_o});
      end
      idle_host();
      @(negedge clk); rst = 1'b0;
      @(negedge clk); req(10'h000, 1'b0); tdat[31:0] = 32'h0ADC0004;
      @(negedge clk);
      vectors++;
      if (cyc_o !== 3'b001 || ack_o !== 1'b0) begin
         errors++; $display("FAIL t6_restart got cyc=%b ack=%b exp 001 0", cyc_o, ack_o);
      end
      tack = 3'b001;
      @(negedge clk);
      vectors++;
      if (ack_o !== 1'b1 || dat_o !== 32'h0ADC0004) begin
         errors++; $display("FAIL t6_read got ack=%b dat=%h exp 1 0adc0004", ack_o, dat_o);
      end
      idle_host();
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_regs_read();
      test_uart0_write();
      test_unmapped();
      test_hung_target();
      test_abort();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
